// File: rtl/fifo_wr_ctrl_if.sv
// Write-side bus of an asynchronous FIFO: producer request/flags plus
// the Gray pointer exchange with the read-domain synchroniser.
//
// Handshake: w_inc is the producer's request and w_full is the
// back-pressure. A write is accepted only in a cycle where w_inc=1 and
// w_full=0, and w_en marks exactly those cycles. A request made while full
// is dropped and not retried; it only sets the sticky w_overflow flag.
interface fifo_wr_ctrl_if #(
  parameter int PTR_WIDTH = 4
);
  logic                 w_inc;
  logic                 w_ovf_clr;
  logic [PTR_WIDTH-1:0] sync_rd_ptr;
  logic                 w_en;
  logic [PTR_WIDTH-2:0] w_addr;
  logic [PTR_WIDTH-1:0] gray_wr_ptr;
  logic                 w_full;
  logic                 w_almost_full;
  logic [PTR_WIDTH-1:0] w_level;
  logic                 w_overflow;

  // Producer side (drives requests, sees flags)
  modport master (
    output w_inc, w_ovf_clr, sync_rd_ptr,
    input  w_en, w_addr, gray_wr_ptr, w_full, w_almost_full, w_level,
           w_overflow
  );

  // Write controller side
  modport slave (
    input  w_inc, w_ovf_clr, sync_rd_ptr,
    output w_en, w_addr, gray_wr_ptr, w_full, w_almost_full, w_level,
           w_overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// Write-pointer controller for an asynchronous FIFO. Keeps a binary write
// pointer with one extra wrap bit, publishes a registered Gray copy for the
// read domain and derives full/level/almost-full against the synchronised
// Gray read pointer. The lagging read pointer only makes flags pessimistic.
module fifo_wr_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int PTR_WIDTH    = 4,
  parameter int AFULL_THRESH = 6
) (
  input  logic           w_clk,
  input  logic           w_rst,
  fifo_wr_ctrl_if.slave  wr
);

  localparam int DEPTH = 1 << (PTR_WIDTH - 1);

  // Full when the write pointer is exactly one lap ahead: in Gray code that
  // is the read pointer with its two top bits inverted.
  localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(3) << (PTR_WIDTH - 2);
  localparam logic [PTR_WIDTH-1:0] AFULL_LVL = PTR_WIDTH'(AFULL_THRESH);

  // Reject illegal parameter sets at elaboration time.
  if (DATA_WIDTH < 1 || PTR_WIDTH < 2 || AFULL_THRESH < 1 ||
      AFULL_THRESH > DEPTH) begin : g_bad_params
    $error("fifo_wr_ctrl: illegal parameter combination");
  end

  logic [PTR_WIDTH-1:0] wptr;
  logic [PTR_WIDTH-1:0] wptr_next;
  logic [PTR_WIDTH-1:0] gray_q;
  logic [PTR_WIDTH-1:0] rd_bin;
  logic [PTR_WIDTH-1:0] level;
  logic                 full;
  logic                 wr_accept;
  logic                 ovf_q;

  // Decode the synchronised Gray read pointer: each binary bit is the XOR of
  // all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      rd_bin[i] = ^(wr.sync_rd_ptr >> i);
    end
  end

  // Flags and next pointer, all evaluated against the current read pointer.
  always_comb begin
    full      = (gray_q == (wr.sync_rd_ptr ^ FULL_MASK));
    wr_accept = wr.w_inc & ~full;
    wptr_next = wptr + {{(PTR_WIDTH-1){1'b0}}, wr_accept};
    level     = wptr - rd_bin;
  end

  // Pointer registers; the Gray copy is always a flop so the read domain
  // never samples a combinational multi-bit transition.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      wptr   <= '0;
      gray_q <= '0;
    end else begin
      wptr   <= wptr_next;
      gray_q <= wptr_next ^ (wptr_next >> 1);
    end
  end

  // Sticky overflow: a dropped write sets it; set has priority over clear.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      ovf_q <= 1'b0;
    end else if (wr.w_inc && full) begin
      ovf_q <= 1'b1;
    end else if (wr.w_ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign wr.w_en          = wr_accept;
  assign wr.w_addr        = wptr[PTR_WIDTH-2:0];
  assign wr.gray_wr_ptr   = gray_q;
  assign wr.w_full        = full;
  assign wr.w_level       = level;
  assign wr.w_almost_full = (level >= AFULL_LVL);
  assign wr.w_overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl with default parameters (depth 8,
// almost-full at 6). Inputs change on the falling edge; outputs are sampled
// 1 time unit after a change or after the rising edge.
module tb_fifo_wr_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_wptr;

  fifo_wr_ctrl_if #(.PTR_WIDTH(4)) bus ();

  fifo_wr_ctrl #(
    .DATA_WIDTH  (8),
    .PTR_WIDTH   (4),
    .AFULL_THRESH(6)
  ) dut (
    .w_clk(clk),
    .w_rst(rst),
    .wr   (bus)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the summary by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Reference Gray encoding of a 4-bit pointer value
  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b & 15);
    return v ^ (v >> 1);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.w_inc = 1'b0;
    bus.w_ovf_clr = 1'b0;
    bus.sync_rd_ptr = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.w_addr !== 3'd0) begin failures++; $display("FAIL rst_addr: got %0d want 0", bus.w_addr); end
    checks++; if (bus.gray_wr_ptr !== 4'b0000) begin failures++; $display("FAIL rst_gray: got %b want 0000", bus.gray_wr_ptr); end
    checks++; if (bus.w_full !== 1'b0) begin failures++; $display("FAIL rst_full: got %b want 0", bus.w_full); end
    checks++; if (bus.w_level !== 4'd0) begin failures++; $display("FAIL rst_level: got %0d want 0", bus.w_level); end
    checks++; if (bus.w_almost_full !== 1'b0) begin failures++; $display("FAIL rst_afull: got %b want 0", bus.w_almost_full); end
    checks++; if (bus.w_overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf: got %b want 0", bus.w_overflow); end
    checks++; if (bus.w_en !== 1'b0) begin failures++; $display("FAIL rst_en_idle: got %b want 0", bus.w_en); end
    bus.w_inc = 1'b1;
    #1;
    checks++; if (bus.w_en !== 1'b1) begin failures++; $display("FAIL rst_en_follow: got %b want 1", bus.w_en); end
    @(posedge clk);
    #1;
    checks++; if (bus.gray_wr_ptr !== 4'b0000) begin failures++; $display("FAIL rst_hold_gray: got %b want 0000", bus.gray_wr_ptr); end
    bus.w_inc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] gray_tbl [8];
    gray_tbl = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                 4'b0111, 4'b0101, 4'b0100, 4'b1100};
    for (int i = 0; i < 8; i++) begin
      bus.w_inc = 1'b1;
      #1;
      checks++; if (bus.w_addr !== 3'(i)) begin failures++; $display("FAIL fill_addr[%0d]: got %0d want %0d", i, bus.w_addr, i); end
      checks++; if (bus.w_en !== 1'b1) begin failures++; $display("FAIL fill_en[%0d]: got %b want 1", i, bus.w_en); end
      checks++; if (bus.w_level !== 4'(i)) begin failures++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, bus.w_level, i); end
      checks++; if (bus.w_almost_full !== (i >= 6)) begin failures++; $display("FAIL fill_afull[%0d]: got %b want %b", i, bus.w_almost_full, (i >= 6)); end
      checks++; if (bus.w_full !== 1'b0) begin failures++; $display("FAIL fill_full[%0d]: got %b want 0", i, bus.w_full); end
      @(posedge clk);
      #1;
      checks++; if (bus.gray_wr_ptr !== gray_tbl[i]) begin failures++; $display("FAIL fill_gray[%0d]: got %b want %b", i, bus.gray_wr_ptr, gray_tbl[i]); end
      @(negedge clk);
    end
    bus.w_inc = 1'b0;
    #1;
    checks++; if (bus.w_level !== 4'd8) begin failures++; $display("FAIL full_level: got %0d want 8", bus.w_level); end
    checks++; if (bus.w_full !== 1'b1) begin failures++; $display("FAIL full_flag: got %b want 1", bus.w_full); end
    checks++; if (bus.w_almost_full !== 1'b1) begin failures++; $display("FAIL full_afull: got %b want 1", bus.w_almost_full); end
    checks++; if (bus.w_addr !== 3'd0) begin failures++; $display("FAIL full_addr: got %0d want 0", bus.w_addr); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 2; k++) begin
      bus.w_inc = 1'b1;
      #1;
      checks++; if (bus.w_en !== 1'b0) begin failures++; $display("FAIL ovf_en[%0d]: got %b want 0", k, bus.w_en); end
      checks++; if (bus.w_overflow !== (k != 0)) begin failures++; $display("FAIL ovf_pre[%0d]: got %b want %b", k, bus.w_overflow, (k != 0)); end
      @(posedge clk);
      #1;
      checks++; if (bus.w_overflow !== 1'b1) begin failures++; $display("FAIL ovf_set[%0d]: got %b want 1", k, bus.w_overflow); end
      checks++; if (bus.w_addr !== 3'd0) begin failures++; $display("FAIL ovf_addr[%0d]: got %0d want 0", k, bus.w_addr); end
      checks++; if (bus.gray_wr_ptr !== 4'b1100) begin failures++; $display("FAIL ovf_gray[%0d]: got %b want 1100", k, bus.gray_wr_ptr); end
      @(negedge clk);
    end
    bus.w_inc = 1'b0;
    bus.w_ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.w_overflow !== 1'b0) begin failures++; $display("FAIL ovf_clr: got %b want 0", bus.w_overflow); end
    @(negedge clk);
    bus.w_ovf_clr = 1'b0;
  endtask

  task automatic test_set_clr_collision();
    bus.w_inc = 1'b1;
    bus.w_ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.w_overflow !== 1'b1) begin failures++; $display("FAIL coll_set_from0: got %b want 1", bus.w_overflow); end
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++; if (bus.w_overflow !== 1'b1) begin failures++; $display("FAIL coll_hold: got %b want 1", bus.w_overflow); end
    @(negedge clk);
    bus.w_inc = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.w_overflow !== 1'b0) begin failures++; $display("FAIL coll_clear: got %b want 0", bus.w_overflow); end
    @(negedge clk);
    bus.w_ovf_clr = 1'b0;
  endtask

  task automatic test_free_slot();
    bus.sync_rd_ptr = 4'b0001;
    #1;
    checks++; if (bus.w_full !== 1'b0) begin failures++; $display("FAIL free_full: got %b want 0", bus.w_full); end
    checks++; if (bus.w_level !== 4'd7) begin failures++; $display("FAIL free_level: got %0d want 7", bus.w_level); end
    checks++; if (bus.w_almost_full !== 1'b1) begin failures++; $display("FAIL free_afull: got %b want 1", bus.w_almost_full); end
    bus.w_inc = 1'b1;
    #1;
    checks++; if (bus.w_en !== 1'b1) begin failures++; $display("FAIL free_en: got %b want 1", bus.w_en); end
    checks++; if (bus.w_addr !== 3'd0) begin failures++; $display("FAIL free_addr: got %0d want 0", bus.w_addr); end
    @(posedge clk);
    #1;
    checks++; if (bus.w_full !== 1'b1) begin failures++; $display("FAIL refill_full: got %b want 1", bus.w_full); end
    checks++; if (bus.w_level !== 4'd8) begin failures++; $display("FAIL refill_level: got %0d want 8", bus.w_level); end
    checks++; if (bus.gray_wr_ptr !== 4'b1101) begin failures++; $display("FAIL refill_gray: got %b want 1101", bus.gray_wr_ptr); end
    checks++; if (bus.w_addr !== 3'd1) begin failures++; $display("FAIL refill_addr: got %0d want 1", bus.w_addr); end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    // Still full with w_inc held: this edge sets overflow mid-burst.
    @(posedge clk);
    #1;
    checks++; if (bus.w_overflow !== 1'b1) begin failures++; $display("FAIL arst_pre_ovf: got %b want 1", bus.w_overflow); end
    #2;
    rst = 1'b1;
    bus.sync_rd_ptr = 4'b0000;
    #1;
    checks++; if (bus.w_addr !== 3'd0) begin failures++; $display("FAIL arst_addr: got %0d want 0", bus.w_addr); end
    checks++; if (bus.gray_wr_ptr !== 4'b0000) begin failures++; $display("FAIL arst_gray: got %b want 0000", bus.gray_wr_ptr); end
    checks++; if (bus.w_overflow !== 1'b0) begin failures++; $display("FAIL arst_ovf: got %b want 0", bus.w_overflow); end
    checks++; if (bus.w_full !== 1'b0) begin failures++; $display("FAIL arst_full: got %b want 0", bus.w_full); end
    checks++; if (bus.w_level !== 4'd0) begin failures++; $display("FAIL arst_level: got %0d want 0", bus.w_level); end
    checks++; if (bus.w_almost_full !== 1'b0) begin failures++; $display("FAIL arst_afull: got %b want 0", bus.w_almost_full); end
    checks++; if (bus.w_en !== 1'b1) begin failures++; $display("FAIL arst_en: got %b want 1", bus.w_en); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.w_addr !== 3'd0) begin failures++; $display("FAIL arst_first_addr: got %0d want 0", bus.w_addr); end
    @(posedge clk);
    #1;
    checks++; if (bus.gray_wr_ptr !== 4'b0001) begin failures++; $display("FAIL arst_first_gray: got %b want 0001", bus.gray_wr_ptr); end
    checks++; if (bus.w_addr !== 3'd1) begin failures++; $display("FAIL arst_next_addr: got %0d want 1", bus.w_addr); end
    @(negedge clk);
    bus.w_inc = 1'b0;
    exp_wptr = 1;
  endtask

  task automatic test_wrap();
    logic [3:0] prev_gray;
    for (int n = 0; n < 20; n++) begin
      bus.sync_rd_ptr = to_gray(exp_wptr - 2);
      bus.w_inc = 1'b1;
      #1;
      checks++; if (bus.w_level !== 4'd2) begin failures++; $display("FAIL wrap_level[%0d]: got %0d want 2", n, bus.w_level); end
      checks++; if (bus.w_full !== 1'b0) begin failures++; $display("FAIL wrap_full[%0d]: got %b want 0", n, bus.w_full); end
      checks++; if (bus.w_addr !== 3'(exp_wptr % 8)) begin failures++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", n, bus.w_addr, exp_wptr % 8); end
      prev_gray = bus.gray_wr_ptr;
      @(posedge clk);
      #1;
      checks++; if ($countones(prev_gray ^ bus.gray_wr_ptr) != 1) begin failures++; $display("FAIL wrap_1bit[%0d]: got %b -> %b want one bit change", n, prev_gray, bus.gray_wr_ptr); end
      checks++; if (bus.gray_wr_ptr !== to_gray(exp_wptr + 1)) begin failures++; $display("FAIL wrap_gray[%0d]: got %b want %b", n, bus.gray_wr_ptr, to_gray(exp_wptr + 1)); end
      exp_wptr++;
      @(negedge clk);
    end
    bus.w_inc = 1'b0;
    bus.sync_rd_ptr = to_gray(exp_wptr - 2);
    #1;
    checks++; if (bus.w_level !== 4'd2) begin failures++; $display("FAIL wrap_end_level: got %0d want 2", bus.w_level); end
    checks++; if (bus.gray_wr_ptr !== to_gray(21)) begin failures++; $display("FAIL wrap_end_gray: got %b want %b", bus.gray_wr_ptr, to_gray(21)); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_wptr = 0;
    test_reset();
    test_fill();
    test_overflow();
    test_set_clr_collision();
    test_free_slot();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory word width; carried for instance compatibility only.
REQ-002 SHALL have parameter PTR_WIDTH, default 4, pointer width; FIFO depth is 2^(PTR_WIDTH-1).
REQ-003 SHALL have parameter AFULL_THRESH, default 6, fill level at or above which almost-full asserts; legal range 1..2^(PTR_WIDTH-1).
REQ-004 SHALL use one clock and an asynchronous active-high reset: w_clk  input  1  write-domain clock, rising-edge.
REQ-005 w_rst  input  1  asynchronous reset, active-high.
REQ-006 w_inc  input  1  write request for the current cycle.
REQ-007 w_ovf_clr  input  1  clears the sticky overflow flag.
REQ-008 sync_rd_ptr  input  PTR_WIDTH  Gray-coded read pointer, already synchronised into w_clk.
REQ-009 w_en  output  1  memory write strobe.
REQ-010 w_addr  output  PTR_WIDTH-1  memory write address.
REQ-011 gray_wr_ptr  output  PTR_WIDTH  registered Gray-coded write pointer, sent to the read-domain synchroniser.
REQ-012 w_full  output  1  FIFO full.
REQ-013 w_almost_full  output  1  fill level >= AFULL_THRESH.
REQ-014 w_level  output  PTR_WIDTH  current fill level, 0..2^(PTR_WIDTH-1).
REQ-015 w_overflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-016 Internal binary write pointer wptr (PTR_WIDTH bits) SHALL increment by 1 on the w_clk edge when w_inc=1 and w_full=0, wrapping modulo 2^PTR_WIDTH.
REQ-017 w_en SHALL be combinational: w_inc AND NOT w_full.
REQ-018 w_addr SHALL equal wptr[PTR_WIDTH-2:0].
REQ-019 gray_wr_ptr SHALL be a flop loaded on the same edge as wptr with bin2gray(wptr_next), where bin2gray(b) = b XOR (b>>1); it SHALL never be driven combinationally, and consecutive values SHALL differ in exactly one bit.
REQ-020 w_full SHALL be combinational: gray_wr_ptr equals sync_rd_ptr with its two MSBs inverted and all other bits equal.
REQ-021 w_level SHALL be combinational: (wptr - gray2bin(sync_rd_ptr)) mod 2^PTR_WIDTH, where gray2bin is the prefix XOR from the MSB down.
REQ-022 w_almost_full SHALL be combinational: w_level >= AFULL_THRESH.
REQ-023 A write request made while full SHALL be dropped: no pointer change and no w_en.
REQ-024 w_overflow SHALL set on the edge after any cycle with w_inc=1 and w_full=0->1; correction: with w_inc=1 and w_full=1.
REQ-025 w_overflow SHALL clear on the edge after w_ovf_clr=1; if set and clear coincide, set wins.
REQ-026 Read-pointer lag from synchronisation SHALL only make full and level pessimistic; a freed slot becomes visible when sync_rd_ptr advances.
REQ-027 A write in the same cycle that sync_rd_ptr changes SHALL be evaluated against the current sync_rd_ptr value.

Reset
REQ-028 While w_rst=1 (asynchronously), wptr=0, gray_wr_ptr=0 and w_overflow=0, giving w_addr=0.
REQ-029 With sync_rd_ptr=0 during reset, w_full=0, w_level=0 and w_almost_full=0; w_en follows w_inc.
REQ-030 Reset asserted mid-operation SHALL discard all pointer state immediately; the read side is reset by the system at the same time.

Verification
REQ-031 Reset, then 8 writes with sync_rd_ptr=0 -> w_addr runs 0..7, gray_wr_ptr ends at 4'b1100, w_level=8, w_full=1; almost_full rises at level 6.
REQ-032 Full, then w_inc=1 for 2 cycles -> w_en=0, wptr unchanged, w_overflow=1 from the next edge; w_ovf_clr pulse -> 0.
REQ-033 Full, then set sync_rd_ptr=4'b0001 -> w_full=0, w_level=7; the next write gives w_full=1 again.
REQ-034 Wrap test: 20 writes with sync_rd_ptr tracking wptr-2 in Gray -> gray_wr_ptr changes 1 bit per write, w_addr wraps 7->0, w_full never asserts, w_level=2.
REQ-035 Overflow set and w_ovf_clr asserted in the same cycle -> w_overflow stays 1.
REQ-036 w_rst pulse asserted mid-burst, between clock edges -> all outputs reach their reset values without waiting for a clock edge; the first write after reset uses w_addr=0.
